// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI shift engine.
//   spi_state_t : engine FSM state (IDLE, SHIFT, DONE)
//   SRC_*       : TX word source select codes for src_sel
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_t;

   localparam logic [1:0] SRC_ECHO = 2'b00;  // previous received word
   localparam logic [1:0] SRC_FIFO = 2'b01;  // TX FIFO head, popped on accept
   localparam logic [1:0] SRC_CMD  = 2'b10;  // command_in
   localparam logic [1:0] SRC_FILL = 2'b11;  // all ones (SD read dummy)

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: sclk generator for the SPI shift engine.
//   clk, rst    : system clock, synchronous active-high reset
//   clear       : restart divider and return sclk phase to idle
//   run         : count while high (engine in SHIFT)
//   sclk_q      : sclk phase, 0 = idle level (caller applies CPOL)
//   lead_pulse  : one-cycle strobe in the cycle whose clock edge makes a leading toggle
//   trail_pulse : same, for a trailing toggle
module spi_clk_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic sclk_q,
   output logic lead_pulse,
   output logic trail_pulse
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_d;
   logic          wrap;

   // With DIV=1 the counter is stuck at 0, so every run cycle wraps.
   assign wrap        = run && (cnt_q == CW'(DIV - 1));
   // Phase 0 is idle, so a toggle out of phase 0 is always a leading edge.
   assign lead_pulse  = wrap && !sclk_q;
   assign trail_pulse = wrap &&  sclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (clear) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (run) begin
         if (wrap) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex SPI master shift engine (SD card path).
//   clk, rst          : system clock, synchronous active-high reset
//   start             : request one word transfer (accepted in IDLE or DONE)
//   src_sel           : TX source (ECHO/FIFO/CMD/FILL), latched at accept
//   lsb_first         : bit order, latched at accept
//   command_in        : command word source
//   fifo_data/fifo_rd : TX FIFO head and its one-cycle pop (combinational)
//   sddi/sddo         : serial data from/to card
//   sclk              : SPI clock, idles at CPOL
//   busy              : high while shifting
//   data_out/rx_valid : last received word and its one-cycle update strobe
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV    = 4,
   parameter bit CPOL   = 1'b0,
   parameter bit CPHA   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        src_sel,
   input  logic              lsb_first,
   input  logic [DATA_W-1:0] command_in,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   input  logic              sddi,
   output logic              sddo,
   output logic              sclk,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              rx_valid
);

   localparam int ECW = $clog2(2 * DATA_W);
   localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_W - 1);

   spi_state_t        state_q, state_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [ECW-1:0]    ecnt_q, ecnt_d;
   logic              lsb_q, lsb_d;
   logic              sddo_q, sddo_d;
   logic              busy_q, busy_d;
   logic              rx_valid_q, rx_valid_d;

   logic              accept;
   logic              sclk_ph, lead_pulse, trail_pulse, sample_pulse;
   logic [DATA_W-1:0] src_word, tx_shifted, rx_shifted;
   logic              src_first_bit, tx_head;

   assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
   assign fifo_rd = accept && !rst && (src_sel == SRC_FIFO);

   spi_clk_div #(.DIV(DIV)) u_div (
      .clk         (clk),
      .rst         (rst),
      .clear       (accept),
      .run         (state_q == SHIFT),
      .sclk_q      (sclk_ph),
      .lead_pulse  (lead_pulse),
      .trail_pulse (trail_pulse)
   );

   assign sample_pulse = CPHA ? trail_pulse : lead_pulse;

   // Source mux. In DONE, data_out is being loaded this very cycle, so ECHO
   // takes rx_sr, which already holds that word.
   always_comb begin
      case (src_sel)
         SRC_ECHO: src_word = (state_q == DONE) ? rx_sr_q : data_out_q;
         SRC_FIFO: src_word = fifo_data;
         SRC_CMD:  src_word = command_in;
         default:  src_word = '1;
      endcase
   end

   assign src_first_bit = lsb_first ? src_word[0] : src_word[DATA_W-1];
   assign tx_head       = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
   // Vacated TX positions fill with ones so an over-run clocks out idle-high.
   assign tx_shifted    = lsb_q ? {1'b1, tx_sr_q[DATA_W-1:1]}
                                : {tx_sr_q[DATA_W-2:0], 1'b1};
   assign rx_shifted    = lsb_q ? {sddi, rx_sr_q[DATA_W-1:1]}
                                : {rx_sr_q[DATA_W-2:0], sddi};

   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      data_out_d = data_out_q;
      ecnt_d     = ecnt_q;
      lsb_d      = lsb_q;
      sddo_d     = sddo_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;

      case (state_q)
         SHIFT: begin
            if (sample_pulse) rx_sr_d = rx_shifted;
            if (lead_pulse || trail_pulse) begin
               ecnt_d = ecnt_q + ECW'(1);
               if (ecnt_q == LAST_EDGE) begin
                  // Final edge is always trailing; in CPHA=1 it also carries
                  // the last sample, hence rx_sr_d rather than rx_sr_q.
                  state_d    = DONE;
                  ecnt_d     = '0;
                  sddo_d     = 1'b1;
                  busy_d     = 1'b0;
                  rx_valid_d = 1'b1;
                  data_out_d = rx_sr_d;
               end else if (!CPHA && trail_pulse) begin
                  tx_sr_d = tx_shifted;
                  sddo_d  = lsb_q ? tx_shifted[0] : tx_shifted[DATA_W-1];
               end else if (CPHA && lead_pulse) begin
                  sddo_d  = tx_head;
                  tx_sr_d = tx_shifted;
               end
            end
         end
         default: begin  // IDLE and DONE behave alike toward a new start
            sddo_d = 1'b1;
            busy_d = 1'b0;
            if (accept) begin
               state_d = SHIFT;
               tx_sr_d = src_word;
               rx_sr_d = '0;
               lsb_d   = lsb_first;
               ecnt_d  = '0;
               busy_d  = 1'b1;
               // CPHA=0 presents bit 0 ahead of the first leading edge.
               sddo_d  = CPHA ? 1'b1 : src_first_bit;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         data_out_q <= '0;
         ecnt_q     <= '0;
         lsb_q      <= 1'b0;
         sddo_q     <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         data_out_q <= data_out_d;
         ecnt_q     <= ecnt_d;
         lsb_q      <= lsb_d;
         sddo_q     <= sddo_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign sclk     = sclk_ph ^ CPOL;
   assign sddo     = sddo_q;
   assign busy     = busy_q;
   assign data_out = data_out_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: mode 0 / DIV=2 / 8-bit instance driven from a
// vector table plus hand sequences, and a mode 3 / DIV=1 / 16-bit instance.
module tb_spi_shift_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance 0: DATA_W=8, DIV=2, CPOL=0, CPHA=0
   logic       start0, lsb0, fifo_rd0, sddi0, sddi_drv0, sddo0, sclk0, busy0, rv0, loop0;
   logic [1:0] src0;
   logic [7:0] cmd0, fifo0, dout0;
   assign sddi0 = loop0 ? sddo0 : sddi_drv0;

   spi_shift_engine #(.DATA_W(8), .DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .src_sel(src0), .lsb_first(lsb0),
      .command_in(cmd0), .fifo_data(fifo0), .fifo_rd(fifo_rd0), .sddi(sddi0),
      .sddo(sddo0), .sclk(sclk0), .busy(busy0), .data_out(dout0), .rx_valid(rv0));

   // instance 1: DATA_W=16, DIV=1, CPOL=1, CPHA=1
   logic        start1, lsb1, fifo_rd1, sddi1, sddo1, sclk1, busy1, rv1;
   logic [1:0]  src1;
   logic [15:0] cmd1, fifo1, dout1;

   spi_shift_engine #(.DATA_W(16), .DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .src_sel(src1), .lsb_first(lsb1),
      .command_in(cmd1), .fifo_data(fifo1), .fifo_rd(fifo_rd1), .sddi(sddi1),
      .sddo(sddo1), .sclk(sclk1), .busy(busy1), .data_out(dout1), .rx_valid(rv1));

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [15:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic sb_check(input logic [15:0] d);
      if (sb.size() == 0) begin
         chk_cnt++;
         $display("FAIL sb_unexpected: rx_valid with data_out %0h, expected none", d);
      end else begin
         check("data_out", {16'h0, d}, {16'h0, sb.pop_front()});
      end
   endtask

   // One word on instance 0 with a mode-0 slave model: slave presents bit 0
   // before accept and the next bit after each trailing edge; master bits are
   // captured after each leading edge. Called one step after a rising edge.
   task automatic xfer0(input logic [1:0] src, input logic lsb, input logic [7:0] cmd,
                        input logic [7:0] fifo, input logic [7:0] rxw, input logic poke,
                        output logic [7:0] cap, output int vn, output int fcnt);
      logic prev;
      int   li, ti;
      cap = '0; vn = -1; fcnt = 0; li = 0; ti = 0;
      sb.push_back({8'h0, rxw});
      src0 = src; lsb0 = lsb; cmd0 = cmd; fifo0 = fifo; start0 = 1'b1;
      sddi_drv0 = lsb ? rxw[0] : rxw[7];
      #1 fcnt += int'(fifo_rd0);
      @(posedge clk); #1;
      start0 = 1'b0;
      // these must be ignored after accept
      src0 = ~src; lsb0 = ~lsb; cmd0 = ~cmd; fifo0 = ~fifo;
      prev = sclk0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         fcnt += int'(fifo_rd0);
         if (poke) start0 = (n == 10 || n == 20);
         if (sclk0 !== prev) begin
            if (sclk0 === 1'b1) begin
               if (li < 8) begin
                  if (lsb) cap[li] = sddo0; else cap[7-li] = sddo0;
               end
               li++;
            end else begin
               ti++;
               if (ti < 8) sddi_drv0 = lsb ? rxw[ti] : rxw[7-ti];
            end
            prev = sclk0;
         end
         if (rv0) begin
            vn = n;
            sb_check({8'h0, dout0});
            check("done_busy_low", busy0, 1'b0);
            break;
         end
      end
      start0 = 1'b0;
      @(posedge clk); #1;
      check("rx_valid_one_cycle", rv0, 1'b0);
   endtask

   typedef struct {
      logic [1:0] src;
      logic       lsb;
      logic [7:0] cmd, fifo, rxw, exp_tx;
      logic       poke;
   } vec_t;

   vec_t vt[6];

   initial begin
      logic [7:0]  cap;
      logic [15:0] cap1;
      int vn, fc, tog, nv, bad_busy, li;
      int vcyc[3];
      logic prev, seen;

      vt[0] = '{src:2'b10, lsb:1'b0, cmd:8'h40, fifo:8'h00, rxw:8'hA5, exp_tx:8'h40, poke:1'b0};
      vt[1] = '{src:2'b01, lsb:1'b1, cmd:8'h00, fifo:8'h3C, rxw:8'h81, exp_tx:8'h3C, poke:1'b0};
      vt[2] = '{src:2'b10, lsb:1'b1, cmd:8'h81, fifo:8'h00, rxw:8'h5A, exp_tx:8'h81, poke:1'b0};
      vt[3] = '{src:2'b00, lsb:1'b0, cmd:8'h00, fifo:8'h00, rxw:8'hC3, exp_tx:8'h5A, poke:1'b1};
      vt[4] = '{src:2'b11, lsb:1'b0, cmd:8'h12, fifo:8'h34, rxw:8'h00, exp_tx:8'hFF, poke:1'b0};
      vt[5] = '{src:2'b00, lsb:1'b1, cmd:8'h00, fifo:8'h00, rxw:8'h96, exp_tx:8'h00, poke:1'b0};

      rst = 1'b1; loop0 = 1'b0; sddi_drv0 = 1'b0;
      start0 = 1'b1; src0 = 2'b01; lsb0 = 1'b0; cmd0 = '0; fifo0 = '0;
      start1 = 1'b0; src1 = 2'b10; lsb1 = 1'b0; cmd1 = '0; fifo1 = '0; sddi1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fifo_rd", fifo_rd0, 1'b0);
      check("rst_sclk0", sclk0, 1'b0);
      check("rst_sddo0", sddo0, 1'b1);
      check("rst_busy0", busy0, 1'b0);
      check("rst_rv0", rv0, 1'b0);
      check("rst_dout0", dout0, 8'h00);
      check("rst_sclk1", sclk1, 1'b1);
      check("rst_sddo1", sddo1, 1'b1);
      start0 = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // table-driven words on instance 0
      for (int i = 0; i < 6; i++) begin
         xfer0(vt[i].src, vt[i].lsb, vt[i].cmd, vt[i].fifo, vt[i].rxw, vt[i].poke, cap, vn, fc);
         check($sformatf("v%0d_sddo_bits", i), cap, vt[i].exp_tx);
         check($sformatf("v%0d_valid_cycle", i), vn, 32);
         check($sformatf("v%0d_fifo_rd_cycles", i), fc, (vt[i].src == 2'b01) ? 1 : 0);
         if (vt[i].poke) begin
            seen = 1'b0;
            repeat (40) begin @(posedge clk); #1; seen |= busy0 | rv0; end
            check("poke_no_extra_xfer", seen, 1'b0);
         end
      end

      // reset at SHIFT edge 5
      src0 = 2'b10; cmd0 = 8'hF0; lsb0 = 1'b0; sddi_drv0 = 1'b1; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; prev = sclk0; tog = 0;
      for (int n = 0; n < 100 && tog < 5; n++) begin
         @(posedge clk); #1;
         if (sclk0 !== prev) begin tog++; prev = sclk0; end
      end
      check("rst_edge5_reached", tog, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_sclk", sclk0, 1'b0);
      check("abort_sddo", sddo0, 1'b1);
      check("abort_busy", busy0, 1'b0);
      check("abort_dout", dout0, 8'h00);
      check("abort_rv", rv0, 1'b0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= rv0 | busy0; end
      check("abort_no_rx_valid", seen, 1'b0);
      xfer0(2'b10, 1'b0, 8'h33, 8'h00, 8'h77, 1'b0, cap, vn, fc);
      check("post_rst_sddo_bits", cap, 8'h33);
      check("post_rst_valid_cycle", vn, 32);

      // FILL, start held, three back-to-back words with loopback
      loop0 = 1'b1; src0 = 2'b11; lsb0 = 1'b0; start0 = 1'b1;
      repeat (3) sb.push_back(16'h00FF);
      @(posedge clk); #1;
      nv = 0; bad_busy = 0;
      for (int n = 1; n <= 150 && nv < 3; n++) begin
         @(posedge clk); #1;
         if (busy0 === rv0) bad_busy++;
         if (rv0) begin
            vcyc[nv] = n; nv++;
            sb_check({8'h0, dout0});
            if (nv == 3) start0 = 1'b0;
         end
      end
      start0 = 1'b0;
      check("b2b_words", nv, 3);
      check("b2b_valid0", vcyc[0], 32);
      check("b2b_valid1", vcyc[1], 65);
      check("b2b_valid2", vcyc[2], 98);
      check("b2b_busy_vs_done", bad_busy, 0);
      @(posedge clk); #1;
      check("b2b_no_fourth", busy0, 1'b0);
      loop0 = 1'b0;

      // instance 1: CPOL=1 CPHA=1 DIV=1 16-bit, CMD 0x8001, slave sends 0x1234
      check("m3_sclk_idle", sclk1, 1'b1);
      src1 = 2'b10; cmd1 = 16'h8001; lsb1 = 1'b0; start1 = 1'b1;
      sb.push_back(16'h1234);
      @(posedge clk); #1;
      start1 = 1'b0; cmd1 = 16'h0000;
      check("m3_sddo_before_lead", sddo1, 1'b1);
      check("m3_sclk_after_accept", sclk1, 1'b1);
      prev = sclk1; li = 0; cap1 = '0; vn = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (sclk1 !== prev) begin
            if (sclk1 === 1'b0) begin  // leading (falling): master presents, slave presents
               if (li < 16) begin
                  cap1[15-li] = sddo1;
                  sddi1 = cmd_bit(16'h1234, li);
               end
               li++;
            end
            prev = sclk1;
         end
         if (rv1) begin vn = n; sb_check(dout1); break; end
      end
      check("m3_sddo_bits", cap1, 16'h8001);
      check("m3_valid_cycle", vn, 32);
      check("m3_sclk_done", sclk1, 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   function automatic logic cmd_bit(input logic [15:0] w, input int i);
      return w[15-i];
   endfunction

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex SPI master shift engine for the SD card path. It succeeds the fixed 8-bit shift/mux pair with a configurable word width, SPI mode, clock divider and bit order, and it generates `sclk` itself. It runs a start/done handshake toward the SD controller FSM, pops the TX FIFO directly, and returns each received word with a one-cycle valid strobe.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits, ≥2
- `DIV`, 4: `sclk` half-period in `clk` cycles, ≥1
- `CPOL`, 0: idle level of `sclk`
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request one word transfer
- `src_sel`  in  2  TX source, latched at accept
- `lsb_first`  in  1  bit order, latched at accept
- `command_in`  in  DATA_W  command word
- `fifo_data`  in  DATA_W  TX FIFO head word
- `fifo_rd`  out  1  one-cycle FIFO pop
- `sddi`  in  1  serial data from card
- `sddo`  out  1  serial data to card
- `sclk`  out  1  SPI clock
- `busy`  out  1  transfer in progress
- `data_out`  out  DATA_W  last received word
- `rx_valid`  out  1  one-cycle strobe when `data_out` updates

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - `sclk`=CPOL, `sddo`=1, `busy`=0.
  - When `start`=1: latch the selected source into `tx_sr`, latch `lsb_first`, clear the divider and edge counters, then go to SHIFT.
- **Source select**
  - 2'b00 ECHO: previous `data_out`.
  - 2'b01 FIFO: `fifo_data`, with `fifo_rd`=1 in the accept cycle only.
  - 2'b10 CMD: `command_in`.
  - 2'b11 FILL: all ones (SD read dummy).
- **SHIFT**
  - `busy`=1.
  - The divider counts 0..DIV-1. On wrap, `sclk` toggles and the edge counter increments (0..2·DATA_W-1).
  - Odd-numbered toggles are leading edges; even-numbered toggles are trailing edges.
  - CPHA=0:
    - The first bit is presented on `sddo` from the cycle after accept.
    - `sddi` is sampled into `rx_sr` on leading edges.
    - `tx_sr` advances on trailing edges, except the final trailing edge.
  - CPHA=1:
    - `tx_sr` advances and presents a bit on leading edges.
    - Sampling happens on trailing edges.
    - `sddo`=1 until the first leading edge.
  - Bit order:
    - `lsb_first`=0: MSB-first, shift left, `rx_sr` fills from bit 0.
    - `lsb_first`=1: LSB-first, mirror image.
  - After edge 2·DATA_W, go to DONE.
- **DONE** (one cycle)
  - `data_out`←`rx_sr`, `rx_valid`=1, `sclk`=CPOL, `sddo`=1.
  - If `start`=1 here, accept it exactly as in IDLE (back-to-back) and go to SHIFT. ECHO selects the word being written this cycle, i.e. `rx_sr`. Otherwise go to IDLE.
- **Ignored inputs**
  - `start` during SHIFT is ignored; no queuing.
  - `src_sel`, `lsb_first`, `command_in` and `fifo_data` are sampled only in the accept cycle.
- **Reset**
  - Reset at any time, mid-transfer included, forces IDLE.
  - Reset values: `sclk`=CPOL, `sddo`=1, `busy`=0, `fifo_rd`=0, `rx_valid`=0, `data_out`=0, all counters 0.
  - An aborted word never produces `rx_valid`.

## Timing
- Accept occurs on the rising edge t0 with `start`=1 in IDLE or DONE.
- SHIFT occupies cycles t0+1 .. t0+2·DATA_W·DIV.
- DONE occurs at cycle t0+2·DATA_W·DIV+1. `rx_valid` and the new `data_out` are visible in that cycle.
- Back-to-back throughput is 2·DATA_W·DIV+1 cycles per word.
- `fifo_rd` is high in the accept cycle (t0) only, combinationally from the accept condition.
- All outputs are registered except `fifo_rd`.
- DIV=1: `sclk` toggles every `clk` cycle, i.e. `sclk` = `clk`/2.

## Structure
- Package `spi_pkg`:
  - State enum `spi_state_t` {IDLE, SHIFT, DONE}.
  - Source constants `SRC_ECHO`, `SRC_FIFO`, `SRC_CMD`, `SRC_FILL`.
- Sub-module `spi_clk_div`:
  - Parameter: `DIV`.
  - Inputs: `clk`, `rst`, `clear`, `run`.
  - Outputs: `sclk_q`, `lead_pulse`, `trail_pulse`.
- The engine owns the FSM, the source mux, `tx_sr`/`rx_sr` and the edge counter.

## Test plan
- CMD 0x40, DATA_W=8, DIV=2, mode 0, MSB-first, `sddi` driven 0xA5 -> `sddo` emits 0,1,0,0,0,0,0,0 on leading edges; `rx_valid` at t0+33; `data_out`=0xA5.
- FIFO source with `fifo_data`=0x3C, `lsb_first`=1 -> `fifo_rd` high exactly one cycle (t0); `sddo` bits 0,0,1,1,1,1,0,0.
- FILL with `start` held high, three words, `sddi` loopback -> words accepted in DONE cycles 33 cycles apart; three `rx_valid` pulses; `data_out`=0xFF each; `busy` stays high except in DONE.
- CPOL=1, CPHA=1, DIV=1, DATA_W=16, CMD 0x8001 -> `sclk` idles high; sampling on rising edges; `sddo`=1 until first falling edge; `rx_valid` at t0+33.
- `rst` asserted at SHIFT edge 5 -> next cycle `sclk`=CPOL, `sddo`=1, `busy`=0, `data_out`=0, no `rx_valid`; a following `start` runs a clean full word.
- ECHO after a word returns 0x5A -> `sddo` retransmits 0x5A; `start` pulses during SHIFT cause no extra transfer.
